// File: rtl/float8_pkg.sv
// Shared float8 format constants and the accumulator FSM state encoding.
package float8_pkg;

  localparam int EXP_W   = 4;
  localparam int MANT_W  = 3;
  localparam int BIAS    = 7;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [7:0] MAX_POS = 8'h7F;
  localparam logic [7:0] MAX_NEG = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/float8_unpack.sv
// Splits a float8 into sign, effective exponent and significand with hidden bit.
module float8_unpack
  import float8_pkg::*;
(
  input  logic [7:0]        value,
  output logic              sign,
  output logic [EXP_W-1:0]  exp_eff,
  output logic [MANT_W:0]   sig
);

  // Subnormals share the exponent of the smallest normal but have no hidden bit
  always_comb begin
    sign    = value[7];
    exp_eff = (value[6:3] == '0) ? EXP_W'(1) : value[6:3];
    sig     = {(value[6:3] != '0), value[2:0]};
  end

endmodule

// File: rtl/float8_accum.sv
// Sequential float8 accumulator: one term per four cycles, sum released on the last term.
module float8_accum
  import float8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  state_t state, next_state;

  logic [7:0]       term_reg;
  logic             last_reg;
  logic [7:0]       acc;

  logic             al_sign;
  logic             al_sub;
  logic [EXP_W-1:0] al_exp;
  logic [6:0]       al_big;
  logic [6:0]       al_small;
  logic [7:0]       sum_reg;

  logic             t_sign, a_sign;
  logic [EXP_W-1:0] t_exp, a_exp;
  logic [MANT_W:0]  t_sig, a_sig;

  logic             term_big;
  logic             big_sign;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [MANT_W:0]  big_sig, small_sig;
  logic [6:0]       small_aligned;

  logic [6:0]       norm_m;
  logic [4:0]       norm_e;
  logic [7:0]       norm_result;

  float8_unpack u_unpack_term (
    .value   (term_reg),
    .sign    (t_sign),
    .exp_eff (t_exp),
    .sig     (t_sig)
  );

  float8_unpack u_unpack_acc (
    .value   (acc),
    .sign    (a_sign),
    .exp_eff (a_exp),
    .sig     (a_sig)
  );

  // Pick the larger-magnitude operand and shift the smaller one into its scale
  always_comb begin
    term_big  = {t_exp, t_sig} >= {a_exp, a_sig};
    big_sign  = term_big ? t_sign : a_sign;
    big_exp   = term_big ? t_exp  : a_exp;
    big_sig   = term_big ? t_sig  : a_sig;
    small_exp = term_big ? a_exp  : t_exp;
    small_sig = term_big ? a_sig  : t_sig;
    exp_diff  = big_exp - small_exp;
    if (exp_diff >= EXP_W'(7)) begin
      small_aligned = '0;
    end else begin
      small_aligned = {small_sig, 3'b000} >> exp_diff;
    end
  end

  // Renormalize the raw sum and encode it, saturating or dropping to subnormal
  always_comb begin
    norm_m = sum_reg[6:0];
    norm_e = {1'b0, al_exp};
    if (sum_reg[7]) begin
      norm_m = sum_reg[7:1];
      norm_e = norm_e + 5'd1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!norm_m[6] && (norm_e > 5'd1)) begin
          norm_m = norm_m << 1;
          norm_e = norm_e - 5'd1;
        end
      end
    end
    if (norm_e > 5'(EXP_MAX)) begin
      norm_result = al_sign ? MAX_NEG : MAX_POS;
    end else if (norm_m[6]) begin
      norm_result = {al_sign, norm_e[3:0], norm_m[5:3]};
    end else begin
      norm_result = {al_sign, 4'd0, norm_m[5:3]};
    end
    if (norm_result[6:0] == 7'd0) begin
      norm_result = 8'h00;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ALIGN;
      end
      ALIGN: next_state = ADD;
      ADD:   next_state = NORM;
      NORM:  next_state = last_reg ? DONE : IDLE;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: capture term, aligned operands, raw sum, then accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      term_reg <= 8'h00;
      last_reg <= 1'b0;
      acc      <= 8'h00;
      al_sign  <= 1'b0;
      al_sub   <= 1'b0;
      al_exp   <= '0;
      al_big   <= '0;
      al_small <= '0;
      sum_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            term_reg <= in_data;
            last_reg <= in_last;
          end
        end
        ALIGN: begin
          al_sign  <= big_sign;
          al_sub   <= t_sign ^ a_sign;
          al_exp   <= big_exp;
          al_big   <= {big_sig, 3'b000};
          al_small <= small_aligned;
        end
        ADD: begin
          if (al_sub) begin
            sum_reg <= {1'b0, al_big} - {1'b0, al_small};
          end else begin
            sum_reg <= {1'b0, al_big} + {1'b0, al_small};
          end
        end
        NORM: acc <= norm_result;
        DONE: begin
          if (out_ready) acc <= 8'h00;
        end
        default: ;
      endcase
    end
  end

endmodule
